// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side consumer.
//   FIFO_WIDTH   : default data word width
//   RD_BUF_DEPTH : words held by the read-side skid buffer
//   OCC_W        : width of the read-side occupancy count (0..RD_BUF_DEPTH)
//   buf_state_e  : skid-buffer fill state; its encoding is the occupancy value
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH   = 8;
  localparam int unsigned RD_BUF_DEPTH = 2;
  localparam int unsigned OCC_W        = 2;

  typedef enum logic [OCC_W-1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_fwft_reader_if.sv
// Signal bundle between the FIFO read port, the reader and the downstream stream.
//   fifo_empty / fifo_rd_data / fifo_rd_en : FIFO read port (registered data)
//   m_valid / m_data / m_ready             : first-word-fall-through output stream
//   flush                                  : synchronous discard request
//   occupancy / word_count                 : status
// Modports: slave = the reader block, master = the environment around it.
interface fifo_fwft_reader_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 fifo_empty;
  logic [WIDTH-1:0]     fifo_rd_data;
  logic                 fifo_rd_en;
  logic                 m_valid;
  logic [WIDTH-1:0]     m_data;
  logic                 m_ready;
  logic                 flush;
  logic [OCC_W-1:0]     occupancy;
  logic [CNT_WIDTH-1:0] word_count;

  modport slave (
    input  fifo_empty, fifo_rd_data, m_ready, flush,
    output fifo_rd_en, m_valid, m_data, occupancy, word_count
  );

  modport master (
    output fifo_empty, fifo_rd_data, m_ready, flush,
    input  fifo_rd_en, m_valid, m_data, occupancy, word_count
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order register buffer. The head entry drives o_head; the spare
// holds the following word. A push and a pop may happen in the same cycle.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_push_data behind the current contents
//   i_pop        : drop the head (only meaningful while o_valid)
//   i_flush      : discard everything; wins over push
//   o_occupancy  : words held, 0..2
//   o_valid      : head holds a word
//   o_head       : head word
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [OCC_W-1:0] o_occupancy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head
);

  buf_state_e       r_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_spare;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BUF_EMPTY;
      r_head  <= '0;
      r_spare <= '0;
    end else if (i_flush) begin
      r_state <= BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (i_push) begin
            r_head  <= i_push_data;
            r_state <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({i_push, i_pop})
            // head leaves and the arriving word replaces it directly
            2'b11: r_head <= i_push_data;
            2'b01: r_state <= BUF_EMPTY;
            2'b10: begin
              r_spare <= i_push_data;
              r_state <= BUF_TWO;
            end
            default: ;
          endcase
        end
        BUF_TWO: begin
          // the reader never pushes into a full buffer without a pop
          if (i_pop) begin
            r_head <= r_spare;
            if (i_push) r_spare <= i_push_data;
            else        r_state <= BUF_ONE;
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

  assign o_occupancy = r_state;
  assign o_valid     = (r_state != BUF_EMPTY);
  assign o_head      = r_head;

endmodule

// File: rtl/fifo_fwft_reader.sv
// Read-side consumer for the async FIFO. Issues fifo_rd_en whenever the word
// it would fetch is guaranteed a slot, tracks the one-cycle read latency with
// an inflight flag, and presents the words as a first-word-fall-through
// valid/ready stream at full throughput. Counts completed transfers.
//   rd_clk, rd_rst_n : read-domain clock, asynchronous active-low reset
//   bus (slave)      : FIFO read port, output stream, flush and status
module fifo_fwft_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = FIFO_WIDTH,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  fifo_fwft_reader_if.slave bus
);

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_word_count;

  logic                 w_pop;
  logic                 w_rd_en;
  logic                 w_valid;
  logic [OCC_W-1:0]     w_occ;
  logic [WIDTH-1:0]     w_head;
  logic [OCC_W:0]       w_committed;

  assign w_pop = w_valid && bus.m_ready;

  // Words that will be held after this edge; a pop implies occupancy >= 1,
  // so the subtraction cannot underflow.
  assign w_committed = {1'b0, w_occ}
                     + {{OCC_W{1'b0}}, r_inflight}
                     - {{OCC_W{1'b0}}, w_pop};

  // Gated by reset so no read is issued while the domain is held in reset.
  assign w_rd_en = rd_rst_n && !bus.fifo_empty && !bus.flush
                && (w_committed <= (OCC_W+1)'(RD_BUF_DEPTH - 1));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_inflight   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) r_word_count <= r_word_count + 1'b1;
    end
  end

  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk         (rd_clk),
    .rst_n       (rd_rst_n),
    .i_push      (r_inflight),
    .i_push_data (bus.fifo_rd_data),
    .i_pop       (w_pop),
    .i_flush     (bus.flush),
    .o_occupancy (w_occ),
    .o_valid     (w_valid),
    .o_head      (w_head)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;
  assign bus.occupancy  = w_occ;
  assign bus.word_count = r_word_count;

endmodule
